// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes two cycles: ISSUE drives the memory, DONE acks the port.
module data_memory_arbiter #(
  parameter int MEM_AWIDTH = 16,
  parameter bit P0_FIRST   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [31:0] LO_MASK =
    (MEM_AWIDTH >= 32) ? 32'hffff_ffff
                       : ((32'd1 << MEM_AWIDTH) - 32'd1);

  typedef struct packed {
    logic        we;
    logic        oor;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic        served;
  logic        served_n;
  logic        last;
  logic        load;
  logic        pick;
  logic        other_req;
  req_t        cur;
  req_t        sel;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic [31:0] rd_val;
  logic        in_issue;
  logic        in_done;

  // served / last: 0 = port 0, 1 = port 1
  assign pick      = (p0_req && p1_req) ? ~last : p1_req;
  assign other_req = served ? p0_req : p1_req;

  always_comb begin
    state_n  = state;
    served_n = served;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_n  = ISSUE;
          served_n = pick;
          load     = 1'b1;
        end
      end
      ISSUE: state_n = DONE;
      DONE: begin
        if (other_req) begin
          state_n  = ISSUE;
          served_n = ~served;
          load     = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel       = '0;
    sel.we    = served_n ? p1_we    : p0_we;
    sel.addr  = served_n ? p1_addr  : p0_addr;
    sel.wdata = served_n ? p1_wdata : p0_wdata;
    sel.oor   = |(sel.addr & ~LO_MASK);
  end

  assign in_issue = (state == ISSUE);
  assign in_done  = (state == DONE);
  assign rd_val   = cur.oor ? 32'd0 : mem_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      served   <= 1'b0;
      last     <= P0_FIRST;
      cur      <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state  <= state_n;
      served <= served_n;
      if (load) begin
        cur <= sel;
      end
      if (in_done) begin
        last <= served;
        if (!cur.we) begin
          if (served) begin
            rdata1_q <= rd_val;
          end else begin
            rdata0_q <= rd_val;
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);

  assign p0_ack = in_done && !served;
  assign p1_ack = in_done && served;
  assign p0_err = p0_ack && cur.oor;
  assign p1_err = p1_ack && cur.oor;

  // read data is visible in the ack cycle, then held in the register
  assign p0_rdata = (p0_ack && !cur.we) ? rd_val : rdata0_q;
  assign p1_rdata = (p1_ack && !cur.we) ? rd_val : rdata1_q;

  assign mem_write = in_issue && cur.we && !cur.oor;
  assign mem_read  = in_issue && !cur.we && !cur.oor;
  assign mem_addr  = (in_issue && !cur.oor) ? cur.addr : 32'd0;
  assign mem_in    = mem_write ? cur.wdata : 32'd0;

endmodule
